// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with a bank of RW registers, a read-only status word and wait-state insertion
module apb_reg_slave #(
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [7:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [15:0] wr_count
);
    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic [15:0] wr_count_q, wr_count_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        is_status, is_err;
    logic [31:0] rd_word;

    // Decode the access latched at setup; outputs depend on registered state only
    always_comb begin
        is_status = addr_q == 8'hFF;
        is_err    = (int'(addr_q) >= NUM_REGS && !is_status) || (is_status && write_q);
        rd_word   = is_status ? {8'h00, err_count_q, wr_count_q} : 32'h0;
        for (int i = 0; i < NUM_REGS; i++)
            if (addr_q == 8'(i)) rd_word = regs_q[i];
        pready    = state_q == READY;
        pslverr   = pready && is_err;
        prdata    = (pready && !write_q && !is_err) ? rd_word : 32'h0;
        wr_count  = wr_count_q;
    end

    // Transfer sequencing, register commit and traffic counters
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        regs_d      = regs_q;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: if (psel && !penable) begin
                addr_d  = paddr;
                write_d = pwrite;
                cnt_d   = WAIT_INIT;
                state_d = (WAIT_CYCLES > 0) ? WAIT : READY;
            end
            WAIT: if (!psel) state_d = IDLE;
                else if (penable) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q <= 4'd1) ? READY : WAIT;
                end
            READY: begin
                state_d = IDLE;
                if (psel && is_err) err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
                if (psel && !is_err && write_q) begin
                    wr_count_d = wr_count_q + 16'd1;
                    for (int i = 0; i < NUM_REGS; i++)
                        if (addr_q == 8'(i)) regs_d[i] = pwdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            addr_q      <= 8'h00;
            write_q     <= 1'b0;
            cnt_q       <= 4'd0;
            regs_q      <= '{default: 32'h0};
            wr_count_q  <= 16'h0;
            err_count_q <= 8'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            regs_q      <= regs_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end
endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB completer holding a parameterized bank of 32-bit read/write registers plus a read-only status word. It is the responder on the peripheral bus driven by the team's APB initiator FSM: it decodes 8-bit addresses, inserts a configurable number of wait states, and flags bad accesses with `pslverr`. The module also exports a count of committed writes so system logic can observe bus traffic.

## Interface
- `NUM_REGS`, default 16: number of RW registers at addresses 0..NUM_REGS-1; legal range 1..255.
- `WAIT_CYCLES`, default 1: number of ACCESS cycles with `pready`=0 before completion; legal range 0..15.
- `pclk`  in  1  APB clock; all state updates on the rising edge.
- `presetn`  in  1  reset, asynchronous, active-low.
- `paddr`  in  8  word address.
- `psel`  in  1  select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `pwdata`  in  32  write data.
- `prdata`  out  32  read data; valid only while `pready`=1 on a read, otherwise 0.
- `pready`  out  1  transfer completes on this cycle.
- `pslverr`  out  1  error response; valid only while `pready`=1, otherwise 0.
- `wr_count`  out  16  committed-write counter.

## Operation
- Address map:
  - 0..NUM_REGS-1: RW registers, reset to 0.
  - 0xFF: STATUS, read-only, = {8'h00, err_count[7:0], wr_count[15:0]}.
  - All other addresses: unmapped.
- Errors, giving `pslverr`=1 at completion:
  - any access to an unmapped address; reads return 0;
  - a write to 0xFF.
  - An errored write changes no register.
- `err_count` increments on each errored completion and saturates at 255.
- `wr_count` increments on each error-free write completion and wraps 0xFFFF -> 0x0000.
- FSM states: IDLE, WAIT, READY.
  - IDLE: on `psel`=1 and `penable`=0 (setup), latch `paddr` and `pwrite` and load cnt=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, otherwise READY.
  - WAIT: each cycle with `psel`=`penable`=1, cnt decrements; at cnt==1 it goes to READY.
  - READY: drive `pready`=1, `pslverr`, and `prdata`. At the next edge, commit the write and update the counters, then go to IDLE.
- Address and direction decode use the values latched at setup.
- `pwdata` is sampled at the READY edge.
- Protocol abort: if `psel`=0 in WAIT or READY, go to IDLE with no write and no counter update.
- Read of a RW register returns its current contents. A write-then-read of the same address returns the new value.

## Timing
- Reset (async assert): state=IDLE, all registers=0, `wr_count`=0, `err_count`=0, `prdata`=0, `pready`=0, `pslverr`=0.
- Reset mid-transfer discards the pending write. Deassertion is synchronous to `pclk` by system convention.
- Transfer length = 2 + WAIT_CYCLES clocks, counted setup-to-completion inclusive. With WAIT_CYCLES=0, `pready`=1 in the first ACCESS cycle.
- `pready`, `pslverr`, and `prdata` are decoded from registered state only. There is no combinational path from `paddr`, `pwrite`, or `pwdata`.
- Write data is visible in the register, and in `wr_count`, one clock after the completion edge.
- Back-to-back: a setup cycle immediately following completion is accepted from IDLE with no idle gap.
- Simultaneous wrap of `wr_count` and its increment is plain modulo-2^16. `err_count` holds at 255.

## Test plan
- Reset, then read 0x00 and 0xFF -> `prdata`=0 for both, `pslverr`=0, and `pready` high exactly on the 3rd cycle of each transfer (WAIT_CYCLES=1).
- Write 0xDEADBEEF to 0x03, then read 0x03 -> read returns 0xDEADBEEF. `wr_count`=1, STATUS=0x0000_0001.
- Write to 0x20 (NUM_REGS=16), then write to 0xFF -> `pslverr`=1 on both. Registers are unchanged, `wr_count` is unchanged, STATUS[23:16]=2.
- WAIT_CYCLES=0: 256 back-to-back writes to 0x00..0x0F cycling -> each transfer is 2 clocks, `wr_count`=0x0100.
- Drop `psel` during WAIT on a write of 0x1234 to 0x05 -> reg 0x05 stays 0 and `wr_count` is unchanged. Then assert `presetn` low mid-transfer -> all outputs 0 asynchronously.
- Preload `wr_count`=0xFFFF via 65535 writes (or force), then one more write -> `wr_count`=0x0000. Force `err_count` to 255 plus one error -> stays 255.
